// File: rtl/et_chord_player.sv
// Ear-training chord sequencer: latches a chord, converts note IDs to voice periods,
// then plays an optional arpeggio followed by the block chord.
module et_chord_player #(
   parameter int unsigned NOTE_CYC  = 50000000,
   parameter int unsigned GAP_CYC   = 10000000,
   parameter int unsigned CHORD_CYC = 100000000,
   parameter int unsigned ID_LO     = 28,
   parameter int unsigned ID_HI     = 63
) (
   input  logic        CLK100MHZ,
   input  logic        CPU_RESETN,
   input  logic        start,
   input  logic        abort,
   input  logic        arp_en,
   input  logic [1:0]  note_num,
   input  logic [6:0]  note_id_0,
   input  logic [6:0]  note_id_1,
   input  logic [6:0]  note_id_2,
   output logic [31:0] clks_per_period_0,
   output logic [31:0] clks_per_period_1,
   output logic [31:0] clks_per_period_2,
   output logic [2:0]  new_period,
   output logic [2:0]  voice_en,
   output logic        busy,
   output logic        done,
   output logic        bad_note
);

   localparam int unsigned CW = 32;

   typedef enum logic [2:0] {
      IDLE, CONV0, CONV1, CONV2, ARP_ON, ARP_GAP, CHORD, FIN
   } state_t;

   state_t          state, state_d;
   logic [CW-1:0]   cnt, cnt_d;
   logic [1:0]      p, p_d;
   logic            arp_q, arp_d;
   logic [1:0]      num_q, num_d;
   logic [6:0]      ids_q [3];
   logic [6:0]      ids_d [3];
   logic [31:0]     per_q [3];
   logic [31:0]     per_d [3];
   logic [2:0]      vmask, vmask_d;
   logic [2:0]      np_d, ve_d;
   logic            busy_d, done_d, bad_d;
   logic [2:0]      conv_hit;
   logic            used, ok;
   logic [31:0]     newp;

   function automatic logic [31:0] base_period(input logic [3:0] idx);
      case (idx)
         4'd0:    return 32'd3057805;
         4'd1:    return 32'd2886184;
         4'd2:    return 32'd2724194;
         4'd3:    return 32'd2571298;
         4'd4:    return 32'd2426982;
         4'd5:    return 32'd2290765;
         4'd6:    return 32'd2162195;
         4'd7:    return 32'd2040840;
         4'd8:    return 32'd1926296;
         4'd9:    return 32'd1818182;
         4'd10:   return 32'd1716135;
         default: return 32'd1619816;
      endcase
   endfunction

   // Octave 0 is C3; each higher octave halves the period.
   function automatic logic [31:0] id_to_period(input logic [6:0] id);
      logic [6:0] d;
      logic [1:0] oct;
      logic [3:0] idx;
      d = 7'(id - 7'(ID_LO));
      if (d >= 7'd24) begin
         oct = 2'd2;
         idx = 4'(d - 7'd24);
      end else if (d >= 7'd12) begin
         oct = 2'd1;
         idx = 4'(d - 7'd12);
      end else begin
         oct = 2'd0;
         idx = 4'(d);
      end
      return base_period(idx) >> (32'(oct) + 32'd2);
   endfunction

   always_comb begin
      state_d  = state;
      cnt_d    = cnt + CW'(1);
      p_d      = p;
      arp_d    = arp_q;
      num_d    = num_q;
      ids_d    = ids_q;
      per_d    = per_q;
      vmask_d  = vmask;
      bad_d    = bad_note;
      np_d     = '0;
      ve_d     = '0;
      used     = 1'b0;
      ok       = 1'b0;
      newp     = '0;

      case (state)
         IDLE: if (start && !abort) begin
            state_d  = CONV0;
            arp_d    = arp_en;
            num_d    = note_num;
            ids_d[0] = note_id_0;
            ids_d[1] = note_id_1;
            ids_d[2] = note_id_2;
         end
         CONV0: state_d = CONV1;
         CONV1: state_d = CONV2;
         CONV2: begin
            if (num_q == 2'd0)  state_d = FIN;
            else if (arp_q) begin
               state_d = ARP_ON;
               p_d     = 2'd0;
            end else            state_d = CHORD;
         end
         ARP_ON:  if (cnt == CW'(NOTE_CYC - 1)) state_d = ARP_GAP;
         ARP_GAP: if (cnt == CW'(GAP_CYC - 1)) begin
            p_d     = p + 2'd1;
            state_d = (p + 2'd1 == num_q) ? CHORD : ARP_ON;
         end
         CHORD:   if (cnt == CW'(CHORD_CYC - 1)) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (abort && state != IDLE) state_d = IDLE;
      if (state_d != state) cnt_d = '0;

      // Period conversion lands in the same cycle the matching CONV state is shown.
      conv_hit = {state_d == CONV2, state_d == CONV1, state_d == CONV0};
      for (int i = 0; i < 3; i++) begin
         if (conv_hit[i]) begin
            used       = 2'(i) < num_d;
            ok         = (ids_d[i] >= 7'(ID_LO)) && (ids_d[i] <= 7'(ID_HI));
            newp       = (used && ok) ? id_to_period(ids_d[i]) : 32'd0;
            np_d[i]    = newp != per_q[i];
            per_d[i]   = newp;
            vmask_d[i] = used && ok;
            bad_d      = ((i == 0) ? 1'b0 : bad_note) | (used && !ok);
         end
      end

      case (state_d)
         ARP_ON:  ve_d = vmask_d & (3'b001 << p_d);
         CHORD:   ve_d = vmask_d;
         default: ve_d = '0;
      endcase
      busy_d = state_d != IDLE;
      done_d = state_d == FIN;
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state      <= IDLE;
         cnt        <= '0;
         p          <= '0;
         arp_q      <= 1'b0;
         num_q      <= '0;
         ids_q      <= '{default: '0};
         per_q      <= '{default: '0};
         vmask      <= '0;
         new_period <= '0;
         voice_en   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         bad_note   <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         p          <= p_d;
         arp_q      <= arp_d;
         num_q      <= num_d;
         ids_q      <= ids_d;
         per_q      <= per_d;
         vmask      <= vmask_d;
         new_period <= np_d;
         voice_en   <= ve_d;
         busy       <= busy_d;
         done       <= done_d;
         bad_note   <= bad_d;
      end
   end

   assign clks_per_period_0 = per_q[0];
   assign clks_per_period_1 = per_q[1];
   assign clks_per_period_2 = per_q[2];

endmodule

// File: tb/tb_et_chord_player.sv
// Scoreboard bench for et_chord_player: stimulus pushes the expected per-cycle trace,
// a negedge monitor pops and compares every busy/done cycle.
module tb_et_chord_player;

   logic        CLK100MHZ = 1'b0;
   logic        CPU_RESETN;
   logic        start, abort, arp_en;
   logic [1:0]  note_num;
   logic [6:0]  note_id_0, note_id_1, note_id_2;
   logic [31:0] clks_per_period_0, clks_per_period_1, clks_per_period_2;
   logic [2:0]  new_period, voice_en;
   logic        busy, done, bad_note;

   typedef struct packed {
      logic [2:0]  np;
      logic [2:0]  ve;
      logic        dn;
      logic        bsy;
      logic        bad;
      logic [31:0] p0;
      logic [31:0] p1;
      logic [31:0] p2;
   } snap_t;

   snap_t       exp_q[$];
   logic [31:0] ep [3];
   logic        ebad;
   logic        mon_en;
   int          n_checks = 0;
   int          n_pass   = 0;

   et_chord_player #(.NOTE_CYC(8), .GAP_CYC(2), .CHORD_CYC(16), .ID_LO(28), .ID_HI(63)) dut (
      .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN),
      .start(start), .abort(abort), .arp_en(arp_en), .note_num(note_num),
      .note_id_0(note_id_0), .note_id_1(note_id_1), .note_id_2(note_id_2),
      .clks_per_period_0(clks_per_period_0), .clks_per_period_1(clks_per_period_1),
      .clks_per_period_2(clks_per_period_2),
      .new_period(new_period), .voice_en(voice_en),
      .busy(busy), .done(done), .bad_note(bad_note)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic push(input int n, input logic [2:0] np, input logic [2:0] ve, input logic dn);
      for (int i = 0; i < n; i++)
         exp_q.push_back('{np: np, ve: ve, dn: dn, bsy: 1'b1, bad: ebad,
                           p0: ep[0], p1: ep[1], p2: ep[2]});
   endtask

   // Monitor: every cycle the DUT is busy or signals done must match the next expected entry.
   always @(negedge CLK100MHZ) begin
      snap_t act, e;
      if (mon_en && CPU_RESETN && (busy || done)) begin
         act = '{np: new_period, ve: voice_en, dn: done, bsy: busy, bad: bad_note,
                 p0: clks_per_period_0, p1: clks_per_period_1, p2: clks_per_period_2};
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_cycle: got %h expected nothing", act);
         end else begin
            e = exp_q.pop_front();
            if (act === e) n_pass++;
            else $display("FAIL trace: got np=%b ve=%b dn=%b bsy=%b bad=%b p=%0d/%0d/%0d expected np=%b ve=%b dn=%b bsy=%b bad=%b p=%0d/%0d/%0d",
                          act.np, act.ve, act.dn, act.bsy, act.bad, act.p0, act.p1, act.p2,
                          e.np, e.ve, e.dn, e.bsy, e.bad, e.p0, e.p1, e.p2);
         end
      end
   end

   task automatic start_chord(input logic [1:0] n, input logic [6:0] i0, input logic [6:0] i1,
                              input logic [6:0] i2, input logic arp);
      @(posedge CLK100MHZ); #1;
      note_num = n; note_id_0 = i0; note_id_1 = i1; note_id_2 = i2; arp_en = arp;
      start = 1'b1;
      @(posedge CLK100MHZ); #1;
      start = 1'b0;
      // Scramble the inputs to show the chord was latched.
      note_num = 2'd1; note_id_0 = 7'h7f; note_id_1 = 7'h7f; note_id_2 = 7'h7f; arp_en = ~arp;
   endtask

   task automatic drain(input string nm);
      int k = 0;
      while (exp_q.size() != 0 && k < 500) begin
         @(posedge CLK100MHZ);
         k++;
      end
      repeat (3) @(posedge CLK100MHZ);
      #1;
      chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
      chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      CPU_RESETN = 1'b0;
      start = 1'b0; abort = 1'b0; arp_en = 1'b0; note_num = '0;
      note_id_0 = '0; note_id_1 = '0; note_id_2 = '0;
      mon_en = 1'b1;
      ep = '{default: 32'd0};
      ebad = 1'b0;
      repeat (3) @(posedge CLK100MHZ);
      #1;
      chk("rst_p0", clks_per_period_0, 0);
      chk("rst_p1", clks_per_period_1, 0);
      chk("rst_p2", clks_per_period_2, 0);
      chk("rst_flags", 32'({new_period, voice_en, busy, done, bad_note}), 0);
      CPU_RESETN = 1'b1;

      // Chord only, three valid notes.
      ep[0] = 32'd764451; push(1, 3'b001, 3'b000, 1'b0);
      ep[1] = 32'd454545; push(1, 3'b010, 3'b000, 1'b0);
      ep[2] = 32'd382225; push(1, 3'b100, 3'b000, 1'b0);
      push(16, 3'b000, 3'b111, 1'b0);
      push(1, 3'b000, 3'b000, 1'b1);
      start_chord(2'd3, 7'd28, 7'd37, 7'd40, 1'b0);
      drain("chord_only");

      // Same chord again: no strobes; a mid-play start must be ignored.
      push(3, 3'b000, 3'b000, 1'b0);
      push(16, 3'b000, 3'b111, 1'b0);
      push(1, 3'b000, 3'b000, 1'b1);
      start_chord(2'd3, 7'd28, 7'd37, 7'd40, 1'b0);
      repeat (8) @(posedge CLK100MHZ);
      #1;
      note_num = 2'd1; note_id_0 = 7'd50; arp_en = 1'b1; start = 1'b1;
      @(posedge CLK100MHZ); #1;
      start = 1'b0;
      drain("repeat");

      // Arpeggio with two notes at the range extremes.
      push(1, 3'b000, 3'b000, 1'b0);
      ep[1] = 32'd101238; push(1, 3'b010, 3'b000, 1'b0);
      ep[2] = 32'd0;      push(1, 3'b100, 3'b000, 1'b0);
      push(8, 3'b000, 3'b001, 1'b0);
      push(2, 3'b000, 3'b000, 1'b0);
      push(8, 3'b000, 3'b010, 1'b0);
      push(2, 3'b000, 3'b000, 1'b0);
      push(16, 3'b000, 3'b011, 1'b0);
      push(1, 3'b000, 3'b000, 1'b1);
      start_chord(2'd2, 7'd28, 7'd63, 7'd0, 1'b1);
      drain("arpeggio");

      // Out-of-range first note.
      ebad = 1'b1;
      ep[0] = 32'd0;      push(1, 3'b001, 3'b000, 1'b0);
      ep[1] = 32'd382225; push(1, 3'b010, 3'b000, 1'b0);
      push(1, 3'b000, 3'b000, 1'b0);
      push(16, 3'b000, 3'b010, 1'b0);
      push(1, 3'b000, 3'b000, 1'b1);
      start_chord(2'd2, 7'd27, 7'd40, 7'd0, 1'b0);
      drain("out_of_range");
      chk("bad_sticky", 32'(bad_note), 1);

      // Abort during the fourth ARP_ON cycle.
      ebad = 1'b0;
      ep[0] = 32'd764451; push(1, 3'b001, 3'b000, 1'b0);
      ep[1] = 32'd0;      push(1, 3'b010, 3'b000, 1'b0);
      push(1, 3'b000, 3'b000, 1'b0);
      push(4, 3'b000, 3'b001, 1'b0);
      start_chord(2'd1, 7'd28, 7'd0, 7'd0, 1'b1);
      repeat (6) @(posedge CLK100MHZ);
      #1 abort = 1'b1;
      @(posedge CLK100MHZ); #1;
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_ve", 32'(voice_en), 0);
      chk("abort_p0_held", clks_per_period_0, 32'd764451);
      drain("abort");

      // Abort together with start in IDLE: start is dropped.
      @(posedge CLK100MHZ); #1;
      note_num = 2'd3; start = 1'b1; abort = 1'b1;
      @(posedge CLK100MHZ); #1;
      start = 1'b0; abort = 1'b0;
      drain("abort_start");

      // Empty chord: four busy cycles, never audible, done pulses.
      ep[0] = 32'd0; push(1, 3'b001, 3'b000, 1'b0);
      push(2, 3'b000, 3'b000, 1'b0);
      push(1, 3'b000, 3'b000, 1'b1);
      start_chord(2'd0, 7'd30, 7'd31, 7'd32, 1'b1);
      drain("empty");

      // Asynchronous reset in the middle of CHORD.
      mon_en = 1'b0;
      start_chord(2'd3, 7'd28, 7'd37, 7'd40, 1'b0);
      repeat (10) @(posedge CLK100MHZ);
      #1;
      chk("pre_reset_ve", 32'(voice_en), 32'd7);
      #2 CPU_RESETN = 1'b0;
      #1;
      chk("areset_p0", clks_per_period_0, 0);
      chk("areset_p1", clks_per_period_1, 0);
      chk("areset_p2", clks_per_period_2, 0);
      chk("areset_flags", 32'({new_period, voice_en, busy, done, bad_note}), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
